// File: rtl/color_pkg.sv
// Shared constants for the animated colour-wheel block generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the grid geometry, hue-wheel length, RGB332 field positions and
// the reserved colour codes used by color_generator and its testbench.
package color_pkg;

    // Grid geometry in blocks; rows at or beyond GRID_Y are off-screen.
    localparam int GRID_X    = 32;
    localparam int GRID_Y    = 24;

    // Hue wheel: 6 segments of 8 steps each.
    localparam int HUE_STEPS = 48;

    // RGB332 field positions inside the 8-bit colour word.
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    // 8'hFF marks an empty cell elsewhere in the display path, so the wheel
    // never produces it; 8'h00 is reserved for off-screen rows and reset.
    localparam logic [7:0] COLOR_EMPTY = 8'hFF;
    localparam logic [7:0] COLOR_BLACK = 8'h00;

endpackage

// File: rtl/color_generator_if.sv
// Pixel-request / colour-response bundle for color_generator.
// Latency: n/a (wiring only).
// Backpressure: none; the generator accepts an index every cycle.
//
// Signals:
//   x_index [4:0] - block column of the pixel being drawn
//   y_index [4:0] - block row of the pixel being drawn
//   advance       - level-sampled animation step request
//   color   [7:0] - registered RGB332 colour (R[7:5] G[4:2] B[1:0])
interface color_generator_if;

    logic [4:0] x_index;
    logic [4:0] y_index;
    logic       advance;
    logic [7:0] color;

    // The pixel pipeline drives indices and advance, the generator returns colour.
    modport master (
        output x_index,
        output y_index,
        output advance,
        input  color
    );

    modport slave (
        input  x_index,
        input  y_index,
        input  advance,
        output color
    );

endinterface

// File: rtl/hue_to_rgb332.sv
// Maps a 6-bit hue (0..47) onto a saturated RGB332 colour.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//
// Ports:
//   h   [5:0] - hue position on the 48-step wheel
//   rgb [7:0] - RGB332 colour for that hue
module hue_to_rgb332
    import color_pkg::*;
(
    input  logic [5:0] h,
    output logic [7:0] rgb
);

    logic [2:0] w_seg;
    logic [2:0] w_frac;
    logic [2:0] w_frac_inv;
    logic [2:0] w_r;
    logic [2:0] w_g;
    logic [1:0] w_b;

    // Segments are 8 steps long, so h/8 and h%8 are plain bit slices.
    assign w_seg      = h[5:3];
    assign w_frac     = h[2:0];
    assign w_frac_inv = 3'd7 - w_frac;

    // Each segment holds one channel at full scale and ramps another, so the
    // result can never be all-zero or all-ones for hues 0..47. Blue has only
    // two bits, hence its ramps drop the fraction's LSB and full scale is 3.
    always_comb begin
        w_r = 3'd0;
        w_g = 3'd0;
        w_b = 2'd0;
        unique case (w_seg)
            3'd0: begin w_r = 3'd7;       w_g = w_frac;     w_b = 2'd0;            end
            3'd1: begin w_r = w_frac_inv; w_g = 3'd7;       w_b = 2'd0;            end
            3'd2: begin w_r = 3'd0;       w_g = 3'd7;       w_b = w_frac[2:1];     end
            3'd3: begin w_r = 3'd0;       w_g = w_frac_inv; w_b = 2'd3;            end
            3'd4: begin w_r = w_frac;     w_g = 3'd0;       w_b = 2'd3;            end
            3'd5: begin w_r = 3'd7;       w_g = 3'd0;       w_b = w_frac_inv[2:1]; end
            // Hues 48..63 cannot reach here from the top level; emit black.
            default: begin w_r = 3'd0;    w_g = 3'd0;       w_b = 2'd0;            end
        endcase
    end

    always_comb begin
        rgb               = COLOR_BLACK;
        rgb[R_MSB:R_LSB]  = w_r;
        rgb[G_MSB:G_LSB]  = w_g;
        rgb[B_MSB:B_LSB]  = w_b;
    end

endmodule

// File: rtl/color_generator.sv
// Animated diagonal colour-wheel generator: colour = wheel(x + y + phase).
// Latency: 1 cycle from x_index/y_index/phase to color.
// Backpressure: none; a new index is accepted and a colour produced every cycle.
//
// Ports:
//   clock   - single clock, rising edge
//   reset_n - asynchronous active-low reset (phase=0, color=8'h00)
//   bus     - slave side of color_generator_if (x_index, y_index, advance in;
//             color out)
module color_generator
    import color_pkg::*;
#(
    parameter int GRID_X    = color_pkg::GRID_X,
    parameter int GRID_Y    = color_pkg::GRID_Y,
    parameter int HUE_STEPS = color_pkg::HUE_STEPS
)
(
    input  logic                clock,
    input  logic                reset_n,
    color_generator_if.slave    bus
);

    logic [5:0] r_phase;
    logic [7:0] r_color;

    logic [6:0] w_sum;
    logic [5:0] w_hue;
    logic       w_in_range;
    logic [7:0] w_rgb;

    // 7-bit sum cannot overflow: worst case 31 + 31 + 47 = 109.
    assign w_sum = 7'(bus.x_index) + 7'(bus.y_index) + 7'(r_phase);
    assign w_hue = 6'(w_sum % 7'(HUE_STEPS));

    // Indices are zero-extended so a full 32-wide/32-tall grid still compares
    // correctly against the 6-bit limit.
    assign w_in_range = ({1'b0, bus.x_index} < 6'(GRID_X)) &&
                        ({1'b0, bus.y_index} < 6'(GRID_Y));

    hue_to_rgb332 u_hue_to_rgb332 (
        .h   (w_hue),
        .rgb (w_rgb)
    );

    // The colour register samples the hue built from the current phase, so an
    // advance on the same edge only affects the following pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_color <= COLOR_BLACK;
        end else begin
            if (bus.advance) begin
                if (r_phase == 6'(HUE_STEPS - 1)) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= r_phase + 6'd1;
                end
            end
            r_color <= w_in_range ? w_rgb : COLOR_BLACK;
        end
    end

    assign bus.color = r_color;

endmodule

// File: tb/tb_color_generator.sv
// Directed self-checking bench for color_generator.
// Latency: expects color one clock after the index/phase it reflects.
// Backpressure: none exercised; the DUT accepts every cycle.
module tb_color_generator;
    import color_pkg::*;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    color_generator_if bus ();

    color_generator dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (bus.color === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, bus.color, exp);
        end
    endtask

    task automatic check_not_reserved(input string tag);
        checks++;
        assert ((bus.color !== COLOR_EMPTY) && (bus.color !== COLOR_BLACK))
        else begin
            failures++;
            $error("FAIL %s got=%h exp=not_FF_not_00 x=%0d y=%0d",
                   tag, bus.color, bus.x_index, bus.y_index);
        end
    endtask

    // Wait for the next rising edge and settle just past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_xy(input int x, input int y);
        bus.x_index = 5'(x);
        bus.y_index = 5'(y);
    endtask

    // Asynchronous reset applied between edges, held across one edge.
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check({tag, "_async"}, 8'h00);
        step();
        check({tag, "_held"}, 8'h00);
        reset_n = 1'b1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b1;
        bus.advance = 1'b0;
        set_xy(0, 0);

        step();
        step();
        do_reset("reset");

        // First edge after release gives a normal colour: h=0 -> R=7.
        step();
        check("first_after_reset", 8'hE0);

        // Latency: new x must not show until the next edge.
        set_xy(8, 0);
        #1;
        check("latency_before_edge", 8'hE0);
        step();
        check("h8_seg1", 8'hFC);

        set_xy(20, 4);  step(); check("h24_seg3", 8'h1F);
        set_xy(30, 10); step(); check("h40_seg5", 8'hE3);
        set_xy(3, 0);   step(); check("h3_seg0_f3", 8'hEC);
        set_xy(13, 0);  step(); check("h13_seg1_f5", 8'h5C);
        set_xy(19, 0);  step(); check("h19_seg2_f3", 8'h1D);
        set_xy(30, 0);  step(); check("h30_seg3_f6", 8'h07);
        set_xy(31, 6);  step(); check("h37_seg4_f5", 8'hA3);
        set_xy(31, 15); step(); check("h46_seg5_f6", 8'hE0);
        set_xy(31, 13); step(); check("h44_seg5_f4", 8'hE1);
        set_xy(0, 23);  step(); check("h23_last_row", 8'h1F);

        // Off-screen rows.
        set_xy(5, 24);  step(); check("row24_black", 8'h00);
        set_xy(5, 31);  step(); check("row31_black", 8'h00);

        // Hold advance for 47 cycles; the last edge still uses phase 46.
        set_xy(31, 23);
        bus.advance = 1'b1;
        repeat (47) @(posedge clock);
        #1;
        bus.advance = 1'b0;
        check("same_edge_uses_old_phase", 8'hF0);
        step();
        check("phase47_h5", 8'hF4);

        // Reset mid-animation discards the phase.
        set_xy(30, 10);
        do_reset("midanim_reset");
        step();
        check("phase_discarded", 8'hE3);

        // 48 pulses from reset wrap the phase back to 0.
        set_xy(0, 0);
        bus.advance = 1'b1;
        repeat (48) step();
        bus.advance = 1'b0;
        step();
        check("wrap48_phase0", 8'hE0);

        // 16 more pulses: phase 16 only if the wrap happened at 47.
        bus.advance = 1'b1;
        repeat (16) step();
        bus.advance = 1'b0;
        step();
        check("phase16_after_64", 8'h1C);

        // Full sweep of every in-range index at every phase.
        do_reset("sweep_reset");
        for (int p = 0; p < HUE_STEPS; p++) begin
            for (int y = 0; y < GRID_Y; y++) begin
                for (int x = 0; x < GRID_X; x++) begin
                    set_xy(x, y);
                    step();
                    check_not_reserved("sweep");
                end
            end
            bus.advance = 1'b1;
            step();
            bus.advance = 1'b0;
        end

        // Reset asserted mid-sweep forces black without a clock edge.
        set_xy(7, 9);
        bus.advance = 1'b1;
        step();
        step();
        bus.advance = 1'b0;
        do_reset("midsweep_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
